// File: rtl/msg_scroll_if.sv
// Write-side character port of the message scroller.
// Ports: wr_valid/wr_data/wr_last from the producer and wr_ready back from the scroller.
// The master modport drives a message in and the slave modport receives it.
interface msg_scroll_if #(
    parameter int CHAR_W = 8
);
    logic              wr_valid;
    logic              wr_ready;
    logic [CHAR_W-1:0] wr_data;
    logic              wr_last;

    modport master (output wr_valid, output wr_data, output wr_last, input  wr_ready);
    modport slave  (input  wr_valid, input  wr_data, input  wr_last, output wr_ready);
endinterface

// File: rtl/msg_scroll_ctrl.sv
// Message scroller: buffers a short character message and slides a WIN-char window across it on each tick_i.
// Latency: the window and pos update one cycle after the last write or tick; abort_i clears one cycle after it is seen.
// Backpressure: wr_ready is low while scrolling, and ticks are ignored outside SCROLL.
// Ports: clk, rstn (async, active-low), tick_i, abort_i, wr (write interface, slave side),
//        busy, win_valid, win_data (char 0 in the LSBs), pos, done.
// Build option: defining SCROLL_WRAP_EN makes the window wrap modulo the message length, so no done pulse occurs.
module msg_scroll_ctrl #(
    parameter int                MSG_DEPTH = 16,
    parameter int                CHAR_W    = 8,
    parameter int                WIN       = 4,
    parameter logic [CHAR_W-1:0] BLANK     = CHAR_W'(8'h20)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         tick_i,
    input  logic                         abort_i,
    msg_scroll_if.slave                  wr,
    output logic                         busy,
    output logic                         win_valid,
    output logic [WIN*CHAR_W-1:0]        win_data,
    output logic [$clog2(MSG_DEPTH)-1:0] pos,
    output logic                         done
);
    localparam int AW = $clog2(MSG_DEPTH);
    localparam int LW = AW + 1;
    localparam int IW = LW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SCROLL} state_t;

    state_t                 state_q, state_d;
    logic [CHAR_W-1:0]      buf_q [MSG_DEPTH];
    logic [CHAR_W-1:0]      buf_d [MSG_DEPTH];
    logic [LW-1:0]          len_q, len_d;
    logic [AW-1:0]          pos_q, pos_d;
    logic [WIN*CHAR_W-1:0]  win_q, win_d;
    logic                   done_q, done_d;
    logic [IW-1:0]          win_idx;
    logic                   wr_acc;
    logic                   at_end;

    assign wr_acc = wr.wr_valid && wr.wr_ready;
    // Last character of the message is under the window's leftmost slot.
    assign at_end = ({1'b0, pos_q} == (len_q - LW'(1)));

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (wr_acc) state_d = wr.wr_last ? ST_SCROLL : ST_LOAD;
            // A full buffer acts as an implicit last character.
            ST_LOAD:   if (wr_acc && (wr.wr_last || len_q == LW'(MSG_DEPTH - 1))) state_d = ST_SCROLL;
            ST_SCROLL: begin
`ifdef SCROLL_WRAP_EN
                state_d = ST_SCROLL;
`else
                if (tick_i && at_end) state_d = ST_IDLE;
`endif
            end
            default:   state_d = ST_IDLE;
        endcase
        if (abort_i) state_d = ST_IDLE;
    end

    // Outputs decoded from the registered state
    always_comb begin
        wr.wr_ready = (state_q != ST_SCROLL);
        busy        = (state_q != ST_IDLE);
        win_valid   = (state_q == ST_SCROLL);
    end

    // Buffer, length, position and pulse next-state
    always_comb begin
        buf_d  = buf_q;
        len_d  = len_q;
        pos_d  = pos_q;
        done_d = 1'b0;
        if (abort_i) begin
            len_d = '0;
            pos_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: if (wr_acc) begin
                    buf_d[0] = wr.wr_data;
                    len_d    = LW'(1);
                    pos_d    = '0;
                end
                ST_LOAD: if (wr_acc) begin
                    buf_d[len_q[AW-1:0]] = wr.wr_data;
                    len_d                = len_q + LW'(1);
                end
                ST_SCROLL: if (tick_i) begin
                    if (at_end) begin
`ifdef SCROLL_WRAP_EN
                        pos_d = '0;
`else
                        pos_d  = '0;
                        len_d  = '0;
                        done_d = 1'b1;
`endif
                    end else begin
                        pos_d = pos_q + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // The window is computed from next-state values, so it is already
    // correct in the first SCROLL cycle and on the cycle after each tick.
    always_comb begin
        win_d   = {WIN{BLANK}};
        win_idx = '0;
        if (state_d == ST_SCROLL) begin
            for (int k = 0; k < WIN; k++) begin
                win_idx = {2'b00, pos_d} + IW'(k);
`ifdef SCROLL_WRAP_EN
                // win_idx < len + WIN, so at most WIN subtractions reduce it modulo len.
                for (int r = 0; r < WIN; r++) begin
                    if (win_idx >= {1'b0, len_d}) win_idx = win_idx - {1'b0, len_d};
                end
                win_d[k*CHAR_W +: CHAR_W] = buf_d[win_idx[AW-1:0]];
`else
                if (win_idx < {1'b0, len_d}) win_d[k*CHAR_W +: CHAR_W] = buf_d[win_idx[AW-1:0]];
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            len_q  <= '0;
            pos_q  <= '0;
            win_q  <= {WIN{BLANK}};
            done_q <= 1'b0;
        end else begin
            len_q  <= len_d;
            pos_q  <= pos_d;
            win_q  <= win_d;
            done_q <= done_d;
        end
    end

    // Message storage has no reset; entries past len are never displayed.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign win_data = win_q;
    assign pos      = pos_q;
    assign done     = done_q;
endmodule

// File: tb/tb_msg_scroll_ctrl.sv
module tb_msg_scroll_ctrl;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        tick_i = 1'b0;
    logic        abort_i = 1'b0;
    logic        busy, win_valid, done;
    logic [31:0] win_data;
    logic [3:0]  pos;

    int n_checks = 0;
    int n_fail   = 0;

    msg_scroll_if #(.CHAR_W(8)) wr_if ();

    msg_scroll_ctrl dut (
        .clk(clk), .rstn(rstn), .tick_i(tick_i), .abort_i(abort_i), .wr(wr_if),
        .busy(busy), .win_valid(win_valid), .win_data(win_data), .pos(pos), .done(done)
    );

    always #5 clk = ~clk;

    // Reference model: the message as a queue, a mode (0 idle, 1 loading, 2 scrolling) and an offset.
    logic [7:0] m_msg[$];
    int         m_st = 0;
    int         m_pos = 0;
    bit         m_done = 0;

    function automatic logic [31:0] str2win(input string s);
        logic [31:0] w = {4{8'h20}};
        for (int k = 0; k < 4 && k < s.len(); k++) w[k*8 +: 8] = s[k];
        return w;
    endfunction

    function automatic logic [31:0] exp_win();
        logic [31:0] w = {4{8'h20}};
        int idx;
        if (m_st == 2) begin
            for (int k = 0; k < 4; k++) begin
                idx = m_pos + k;
`ifdef SCROLL_WRAP_EN
                w[k*8 +: 8] = m_msg[idx % m_msg.size()];
`else
                if (idx < m_msg.size()) w[k*8 +: 8] = m_msg[idx];
`endif
            end
        end
        return w;
    endfunction

    function automatic logic [39:0] exp_all();
        return {(m_st != 2), (m_st != 0), (m_st == 2), m_done, 4'(m_pos), exp_win()};
    endfunction

    function automatic logic [39:0] dut_all();
        return {wr_if.wr_ready, busy, win_valid, done, pos, win_data};
    endfunction

    function automatic void model_reset();
        m_st = 0; m_pos = 0; m_done = 0;
        m_msg.delete();
    endfunction

    // Apply one cycle of inputs, advance the model, and return at posedge+1.
    task automatic step(input bit tk, input bit ab, input bit v, input logic [7:0] d, input bit l);
        bit acc;
        tick_i = tk; abort_i = ab;
        wr_if.wr_valid = v; wr_if.wr_data = d; wr_if.wr_last = l;
        acc = v && (m_st != 2);
        m_done = 0;
        if (ab) begin
            m_st = 0; m_pos = 0; m_msg.delete();
        end else if (m_st == 0) begin
            if (acc) begin
                m_msg.delete(); m_msg.push_back(d); m_pos = 0;
                m_st = l ? 2 : 1;
            end
        end else if (m_st == 1) begin
            if (acc) begin
                m_msg.push_back(d);
                if (l || m_msg.size() == 16) m_st = 2;
            end
        end else if (tk) begin
            if (m_pos == m_msg.size() - 1) begin
`ifdef SCROLL_WRAP_EN
                m_pos = 0;
`else
                m_st = 0; m_pos = 0; m_done = 1; m_msg.delete();
`endif
            end else begin
                m_pos++;
            end
        end
        @(posedge clk); #1;
        tick_i = 0; abort_i = 0; wr_if.wr_valid = 0; wr_if.wr_last = 0;
    endtask

    task automatic load_str(input string s);
        for (int i = 0; i < s.len(); i++) step(0, 0, 1, s[i], i == s.len() - 1);
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({wr_if.wr_ready, busy, win_valid, done, pos, win_data} !== {4'b1000, 4'd0, 32'h20202020}) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", dut_all(), {4'b1000, 4'd0, 32'h20202020});
        end
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
    endtask

`ifndef SCROLL_WRAP_EN
    task automatic test_abcdef();
        string exp_w[5] = '{"BCDE", "CDEF", "DEF ", "EF  ", "F   "};
        string s = "ABCDEF";
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1, s[i], i == 5);
            if (i < 5) begin
                n_checks++;
                if ({busy, wr_if.wr_ready, win_valid} !== 3'b110) begin
                    n_fail++; $display("FAIL abcdef_load%0d: got %b want 110", i, {busy, wr_if.wr_ready, win_valid});
                end
            end
        end
        n_checks++;
        if ({wr_if.wr_ready, win_valid, pos, win_data} !== {2'b01, 4'd0, str2win("ABCD")}) begin
            n_fail++; $display("FAIL abcdef_first: got %h want %h", {wr_if.wr_ready, win_valid, pos, win_data}, {2'b01, 4'd0, str2win("ABCD")});
        end
        for (int t = 0; t < 5; t++) begin
            step(1, 0, 0, 8'h00, 0);
            n_checks++;
            if ({done, pos, win_data} !== {1'b0, 4'(t + 1), str2win(exp_w[t])}) begin
                n_fail++; $display("FAIL abcdef_tick%0d: got %h want %h", t + 1, {done, pos, win_data}, {1'b0, 4'(t + 1), str2win(exp_w[t])});
            end
        end
        step(1, 0, 0, 8'h00, 0);
        n_checks++;
        if ({done, win_valid, busy, wr_if.wr_ready, pos, win_data} !== {4'b1001, 4'd0, 32'h20202020}) begin
            n_fail++; $display("FAIL abcdef_done: got %h want %h", {done, win_valid, busy, wr_if.wr_ready, pos, win_data}, {4'b1001, 4'd0, 32'h20202020});
        end
        step(0, 0, 0, 8'h00, 0);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL abcdef_done_pulse: got %b want 0", done);
        end
    endtask
`else
    task automatic test_wrap();
        string exp_w[4] = '{"YZXY", "ZXYZ", "XYZX", "YZXY"};
        int    exp_p[4] = '{1, 2, 0, 1};
        load_str("XYZ");
        n_checks++;
        if (win_data !== str2win("XYZX")) begin
            n_fail++; $display("FAIL wrap_first: got %h want %h", win_data, str2win("XYZX"));
        end
        for (int t = 0; t < 4; t++) begin
            step(1, 0, 0, 8'h00, 0);
            n_checks++;
            if ({done, win_valid, pos, win_data} !== {2'b01, 4'(exp_p[t]), str2win(exp_w[t])}) begin
                n_fail++; $display("FAIL wrap_tick%0d: got %h want %h", t + 1, {done, win_valid, pos, win_data}, {2'b01, 4'(exp_p[t]), str2win(exp_w[t])});
            end
        end
        step(0, 1, 0, 8'h00, 0);
    endtask
`endif

    task automatic test_full16();
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1, 8'($urandom_range(33, 126)), 0);
            if (i < 15) begin
                n_checks++;
                if ({busy, wr_if.wr_ready} !== 2'b11) begin
                    n_fail++; $display("FAIL full16_load%0d: got %b want 11", i, {busy, wr_if.wr_ready});
                end
            end
        end
        n_checks++;
        if ({busy, wr_if.wr_ready, win_valid, pos, win_data} !== {3'b101, 4'd0, m_msg[3], m_msg[2], m_msg[1], m_msg[0]}) begin
            n_fail++; $display("FAIL full16_scroll: got %h want %h", {busy, wr_if.wr_ready, win_valid, pos, win_data}, {3'b101, 4'd0, m_msg[3], m_msg[2], m_msg[1], m_msg[0]});
        end
        step(0, 0, 1, 8'h41, 1);
        n_checks++;
        if (dut_all() !== exp_all()) begin
            n_fail++; $display("FAIL full16_17th: got %h want %h", dut_all(), exp_all());
        end
        step(0, 1, 0, 8'h00, 0);
    endtask

    task automatic test_abort_tick();
        load_str("HELLO");
        step(1, 0, 0, 8'h00, 0);
        step(1, 0, 0, 8'h00, 0);
        step(1, 1, 0, 8'h00, 0);
        n_checks++;
        if ({busy, wr_if.wr_ready, win_valid, done, pos, win_data} !== {4'b0100, 4'd0, 32'h20202020}) begin
            n_fail++; $display("FAIL abort_tick: got %h want %h", {busy, wr_if.wr_ready, win_valid, done, pos, win_data}, {4'b0100, 4'd0, 32'h20202020});
        end
        step(0, 0, 1, 8'h4D, 1);
        n_checks++;
        if ({win_valid, pos, win_data} !== {1'b1, 4'd0, str2win("M")}) begin
            n_fail++; $display("FAIL abort_reload: got %h want %h", {win_valid, pos, win_data}, {1'b1, 4'd0, str2win("M")});
        end
        step(0, 1, 0, 8'h00, 0);
        // A write in IDLE coinciding with abort is dropped.
        step(0, 1, 1, 8'h5A, 1);
        n_checks++;
        if ({busy, win_valid, win_data} !== {2'b00, 32'h20202020}) begin
            n_fail++; $display("FAIL abort_write: got %h want %h", {busy, win_valid, win_data}, {2'b00, 32'h20202020});
        end
    endtask

    task automatic test_idle_ticks_q();
        step(1, 0, 0, 8'h00, 0);
        n_checks++;
        if ({busy, pos, win_data} !== {1'b0, 4'd0, 32'h20202020}) begin
            n_fail++; $display("FAIL idle_tick: got %h want %h", {busy, pos, win_data}, {1'b0, 4'd0, 32'h20202020});
        end
        step(0, 0, 1, 8'h50, 0);
        step(1, 0, 0, 8'h00, 0);
        n_checks++;
        if ({busy, win_valid, pos, win_data} !== {2'b10, 4'd0, 32'h20202020}) begin
            n_fail++; $display("FAIL load_tick: got %h want %h", {busy, win_valid, pos, win_data}, {2'b10, 4'd0, 32'h20202020});
        end
        step(0, 1, 0, 8'h00, 0);
        step(0, 0, 1, 8'h51, 1);
        n_checks++;
        if ({win_valid, win_data} !== {1'b1, str2win("Q")}) begin
            n_fail++; $display("FAIL q_window: got %h want %h", {win_valid, win_data}, {1'b1, str2win("Q")});
        end
        step(1, 0, 0, 8'h00, 0);
`ifdef SCROLL_WRAP_EN
        n_checks++;
        if ({done, win_valid, pos, win_data} !== {2'b01, 4'd0, str2win("QQQQ")}) begin
            n_fail++; $display("FAIL q_tick: got %h want %h", {done, win_valid, pos, win_data}, {2'b01, 4'd0, str2win("QQQQ")});
        end
        step(0, 1, 0, 8'h00, 0);
`else
        n_checks++;
        if ({done, win_valid, busy, win_data} !== {3'b100, 32'h20202020}) begin
            n_fail++; $display("FAIL q_tick: got %h want %h", {done, win_valid, busy, win_data}, {3'b100, 32'h20202020});
        end
`endif
    endtask

    task automatic test_reset_mid_scroll();
        load_str("ABCDEF");
        step(1, 0, 0, 8'h00, 0);
        step(1, 0, 0, 8'h00, 0);
        n_checks++;
        if ({pos, win_data} !== {4'd2, str2win("CDEF")}) begin
            n_fail++; $display("FAIL mid_scroll_pos: got %h want %h", {pos, win_data}, {4'd2, str2win("CDEF")});
        end
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if ({wr_if.wr_ready, busy, win_valid, done, pos, win_data} !== {4'b1000, 4'd0, 32'h20202020}) begin
            n_fail++; $display("FAIL async_reset: got %h want %h", dut_all(), {4'b1000, 4'd0, 32'h20202020});
        end
        #3 rstn = 1'b1;
        model_reset();
        @(posedge clk); #1;
        n_checks++;
        if ({wr_if.wr_ready, busy} !== 2'b10) begin
            n_fail++; $display("FAIL after_reset: got %b want 10", {wr_if.wr_ready, busy});
        end
    endtask

    task automatic test_random();
        bit tk, ab, v, l;
        for (int c = 0; c < 1500; c++) begin
            ab = ($urandom_range(0, 39) == 0);
            tk = ($urandom_range(0, 2) == 0);
            v  = ($urandom_range(0, 1) == 0);
            l  = ($urandom_range(0, 4) == 0);
            step(tk, ab, v, 8'($urandom_range(33, 126)), l);
            n_checks++;
            if (dut_all() !== exp_all()) begin
                n_fail++; $display("FAIL random_cycle%0d: got %h want %h", c, dut_all(), exp_all());
            end
        end
    endtask

    initial begin
        wr_if.wr_valid = 0; wr_if.wr_data = 8'h00; wr_if.wr_last = 0;
        test_reset();
`ifdef SCROLL_WRAP_EN
        test_wrap();
`else
        test_abcdef();
`endif
        test_full16();
        test_abort_tick();
        test_idle_ticks_q();
        test_reset_mid_scroll();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
